hdmi_timing_gen_mw: RTL and testbench
=====================================

# hdmi_timing_gen_mw

Parametrised video timing generator and pixel compositor for the ADV7513 HDMI transmitter; successor to the fixed 1024x768 single-window controller. It generates HSYNC/VSYNC/DE with configurable porches and polarities, and composites up to NUM_WIN rectangular pixel windows, each fed by a pixel source through a fixed-latency request/data handshake. It also generates built-in test patterns and a frame counter. It sits between the frame-buffer/overlay readers and the ADV7513 pins.

## Interface
- HA, 1024: active pixels per line
- HF / HS / HB, 24 / 136 / 160: horizontal front porch, sync width, back porch
- VA, 768: active lines
- VF / VS / VB, 3 / 6 / 29: vertical front porch, sync width, back porch
- HS_POL / VS_POL, 1 / 1: active level of HSYNC / VSYNC
- R_W / G_W / B_W, 5 / 6 / 5: colour widths; PW = R_W+G_W+B_W
- NUM_WIN, 3: overlay windows (1..8); index 0 has highest priority
- DATA_LATENCY, 1: cycles from WIN_REQ to valid WIN_DATA (1..4)
- ADV7513_PCLK  in  1  pixel clock; the only clock
- RESETN  in  1  asynchronous, active-low reset
- TEST_MODE  in  2  0 normal, 1 colour bars, 2 checkerboard, 3 solid BG_COLOR
- BG_COLOR  in  PW  active-area colour outside all windows
- WIN_EN  in  NUM_WIN  per-window enable
- WIN_X / WIN_Y / WIN_W / WIN_H  in  12*NUM_WIN each  window origin and size, packed, window i in bits [12i+11:12i]
- WIN_DATA  in  PW*NUM_WIN  pixel from source i
- WIN_REQ  out  NUM_WIN  pixel request to source i
- ADV7513_HSYNC / ADV7513_VSYNC  out  1  sync outputs, polarity per parameter
- ADV7513_DE  out  1  data enable
- ADV7513_R / G / B  out  R_W / G_W / B_W  pixel colour
- FRAME_NEW  out  1  one-cycle pulse at start of vertical blanking
- FRAME_CNT  out  16  completed-frame count

## Operation
- 12-bit counters h (0..HT-1, HT=HA+HF+HS+HB) and v (0..VT-1); v increments when h wraps; both wrap to 0 together at end of frame.
- Raw timing at counter (h,v): active = h<HA && v<VA; hsync = HA+HF <= h < HA+HF+HS; vsync = VA+VF <= v < VA+VF+VS.
- Shadow registers: TEST_MODE, BG_COLOR, WIN_* sampled only on the cycle the counters are at (HT-1,VT-1), taking effect from pixel (0,0). Mid-frame input changes are invisible until the next frame.
- Window i hit: WIN_EN[i] && W>0 && H>0 && X<=h<X+W && Y<=v<Y+H && active, with 13-bit sums (no wrap); windows are clipped to the active area.
- WIN_REQ[i] asserted one cycle after any counter state that hits window i. All hit windows are requested even when overlapped. Sources own their address counters.
- Pipeline: timing and hit vector are delayed so WIN_DATA is sampled exactly DATA_LATENCY cycles after the corresponding WIN_REQ. The compositor picks the lowest-index hit window's data, else BG_COLOR; it outputs 0 when not active.
- TEST_MODE 1: 8 vertical bars, width HA>>3, last bar extends to HA, order white, yellow, cyan, green, magenta, red, blue, black (full-scale components). In modes 1-3, WIN_REQ stays low.
- TEST_MODE 2: white when h[5]^v[5]=0, else black. TEST_MODE 3: BG_COLOR everywhere active.
- FRAME_NEW pulses with the output-aligned timing on the first output cycle of line VA, h=0. FRAME_CNT increments on the same cycle and wraps 0xFFFF->0.

## Timing
- Outputs (sync, DE, RGB) are registered. The counter state at cycle t appears on the pins at t+DATA_LATENCY+2. All outputs keep a fixed relative alignment.
- Reset (asynchronous, takes effect immediately): h=v=0; HSYNC=~HS_POL; VSYNC=~VS_POL; DE=0; RGB=0; WIN_REQ=0; FRAME_NEW=0; FRAME_CNT=0; shadows = mode 0, windows disabled, BG 0; pipeline flushed to blank.
- After RESETN deasserts, counting starts at the first clock edge. The pins show blank until the pipeline fills.
- Reset mid-frame aborts the frame; no FRAME_NEW or count is generated for it.
- A window at X=HA-1 with W=1 requests exactly one pixel per line. Windows with X>=HA or Y>=VA never request.

## Test plan
- Small params HA=16, HF=2, HS=3, HB=3, VA=8, VF=1, VS=2, VB=1, HS_POL=0, DATA_LATENCY=2 -> line period 24; HSYNC low for 3 cycles, 2 cycles after DE falls; DE high 16 cycles per line for 8 lines; frame 288 cycles; FRAME_CNT=3 after 3 frames.
- Window 0 at X=4, Y=2, W=3, H=2, source returns data=h after 2 cycles -> WIN_REQ[0] high for 3 cycles on 2 lines; RGB shows 4,5,6 aligned with DE positions 4-6 of lines 2-3; other active pixels = BG_COLOR 0x1234.
- Windows 0 and 1 overlapping at same rectangle, data 0xAAAA / 0x5555 -> both requested; output 0xAAAA. Disable window 0 mid-frame -> change applies only from the next frame.
- TEST_MODE=1 with HA=16 -> bars 2 pixels wide: 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000; WIN_REQ stays 0.
- Window X=15, W=4 -> one request per line (clipped). W=0 -> no requests.
- Assert RESETN low mid-line -> all outputs immediately at reset values. After release, the first DE rises exactly DATA_LATENCY+2 cycles after the first clock edge.

Source files
------------

// File: rtl/hdmi_timing_gen_mw.sv
// ADV7513 video timing generator with NUM_WIN prioritised overlay windows,
// built-in test patterns and a frame counter; all pins registered.

module hdmi_win_hit_mw (
    input  logic        en_i,
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    input  logic [11:0] w_i,
    input  logic [11:0] h_i,
    input  logic [11:0] hpos_i,
    input  logic [11:0] vpos_i,
    input  logic        act_i,
    output logic        hit_o
);
    logic [12:0] xe, ye;

    // 13-bit ends so a window hanging off the active area never wraps
    assign xe    = {1'b0, x_i} + {1'b0, w_i};
    assign ye    = {1'b0, y_i} + {1'b0, h_i};
    assign hit_o = en_i && act_i && (|w_i) && (|h_i) &&
                   (hpos_i >= x_i) && ({1'b0, hpos_i} < xe) &&
                   (vpos_i >= y_i) && ({1'b0, vpos_i} < ye);
endmodule

module hdmi_timing_gen_mw #(
    parameter int HA           = 1024,
    parameter int HF           = 24,
    parameter int HS           = 136,
    parameter int HB           = 160,
    parameter int VA           = 768,
    parameter int VF           = 3,
    parameter int VS           = 6,
    parameter int VB           = 29,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int R_W          = 5,
    parameter int G_W          = 6,
    parameter int B_W          = 5,
    parameter int NUM_WIN      = 3,
    parameter int DATA_LATENCY = 1
) (
    input  logic                                 ADV7513_PCLK,
    input  logic                                 RESETN,
    input  logic [1:0]                           TEST_MODE,
    input  logic [R_W+G_W+B_W-1:0]               BG_COLOR,
    input  logic [NUM_WIN-1:0]                   WIN_EN,
    input  logic [12*NUM_WIN-1:0]                WIN_X,
    input  logic [12*NUM_WIN-1:0]                WIN_Y,
    input  logic [12*NUM_WIN-1:0]                WIN_W,
    input  logic [12*NUM_WIN-1:0]                WIN_H,
    input  logic [(R_W+G_W+B_W)*NUM_WIN-1:0]     WIN_DATA,
    output logic [NUM_WIN-1:0]                   WIN_REQ,
    output logic                                 ADV7513_HSYNC,
    output logic                                 ADV7513_VSYNC,
    output logic                                 ADV7513_DE,
    output logic [R_W-1:0]                       ADV7513_R,
    output logic [G_W-1:0]                       ADV7513_G,
    output logic [B_W-1:0]                       ADV7513_B,
    output logic                                 FRAME_NEW,
    output logic [15:0]                          FRAME_CNT
);
    localparam int PW = R_W + G_W + B_W;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int L  = DATA_LATENCY;

    typedef struct packed {
        logic               act;
        logic               hs;
        logic               vs;
        logic               fn;
        logic [NUM_WIN-1:0] hit;
        logic [PW-1:0]      col;
    } stage_t;

    logic [11:0]           h_q, v_q;
    logic [1:0]            mode_q;
    logic [PW-1:0]         bg_q;
    logic [NUM_WIN-1:0]    wen_q;
    logic [12*NUM_WIN-1:0] wx_q, wy_q, ww_q, wh_q;
    logic                  h_end, v_end, act;
    logic [NUM_WIN-1:0]    hit;
    logic [2:0]            bar;
    stage_t                stg_d, so;
    stage_t                stg_q [0:L];
    logic [PW-1:0]         pix_d, pix_q;
    logic                  hs_q, vs_q, de_q, fn_q;
    logic [15:0]           cnt_q;

    assign h_end = (h_q == 12'(HT-1));
    assign v_end = (v_q == 12'(VT-1));
    assign act   = (h_q < 12'(HA)) && (v_q < 12'(VA));

    // Configuration is latched on the last pixel so a frame is never torn
    always_ff @(posedge ADV7513_PCLK or negedge RESETN) begin
        if (!RESETN) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= '0;
            bg_q   <= '0;
            wen_q  <= '0;
            wx_q   <= '0;
            wy_q   <= '0;
            ww_q   <= '0;
            wh_q   <= '0;
        end else begin
            h_q <= h_end ? 12'd0 : h_q + 12'd1;
            if (h_end) v_q <= v_end ? 12'd0 : v_q + 12'd1;
            if (h_end && v_end) begin
                mode_q <= TEST_MODE;
                bg_q   <= BG_COLOR;
                wen_q  <= WIN_EN;
                wx_q   <= WIN_X;
                wy_q   <= WIN_Y;
                ww_q   <= WIN_W;
                wh_q   <= WIN_H;
            end
        end
    end

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        hdmi_win_hit_mw u_hit (
            .en_i   (wen_q[i]),
            .x_i    (wx_q[12*i +: 12]),
            .y_i    (wy_q[12*i +: 12]),
            .w_i    (ww_q[12*i +: 12]),
            .h_i    (wh_q[12*i +: 12]),
            .hpos_i (h_q),
            .vpos_i (v_q),
            .act_i  (act),
            .hit_o  (hit[i])
        );
    end

    // Bar index by threshold compare; the last bar absorbs the HA remainder
    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (h_q >= 12'(k * (HA >> 3))) bar = 3'(k);
    end

    always_comb begin
        stg_d     = '0;
        stg_d.act = act;
        stg_d.hs  = (h_q >= 12'(HA+HF)) && (h_q < 12'(HA+HF+HS));
        stg_d.vs  = (v_q >= 12'(VA+VF)) && (v_q < 12'(VA+VF+VS));
        stg_d.fn  = (h_q == 12'd0) && (v_q == 12'(VA));
        case (mode_q)
            2'd0: begin
                stg_d.hit = hit;
                stg_d.col = bg_q;
            end
            2'd1:    stg_d.col = {{R_W{~bar[1]}}, {G_W{~bar[2]}}, {B_W{~bar[0]}}};
            2'd2:    stg_d.col = {PW{~(h_q[5] ^ v_q[5])}};
            default: stg_d.col = bg_q;
        endcase
    end

    // Stage 0 doubles as the request register; stage L meets WIN_DATA
    always_ff @(posedge ADV7513_PCLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int k = 0; k <= L; k++) stg_q[k] <= '0;
        end else begin
            stg_q[0] <= stg_d;
            for (int k = 1; k <= L; k++) stg_q[k] <= stg_q[k-1];
        end
    end

    assign so      = stg_q[L];
    assign WIN_REQ = stg_q[0].hit;

    always_comb begin
        pix_d = so.col;
        for (int i = NUM_WIN-1; i >= 0; i--)
            if (so.hit[i]) pix_d = WIN_DATA[i*PW +: PW];
        if (!so.act) pix_d = '0;
    end

    always_ff @(posedge ADV7513_PCLK or negedge RESETN) begin
        if (!RESETN) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            pix_q <= '0;
            fn_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            hs_q  <= so.hs ? HS_POL : ~HS_POL;
            vs_q  <= so.vs ? VS_POL : ~VS_POL;
            de_q  <= so.act;
            pix_q <= pix_d;
            fn_q  <= so.fn;
            if (so.fn) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign ADV7513_HSYNC = hs_q;
    assign ADV7513_VSYNC = vs_q;
    assign ADV7513_DE    = de_q;
    assign ADV7513_R     = pix_q[PW-1 -: R_W];
    assign ADV7513_G     = pix_q[B_W +: G_W];
    assign ADV7513_B     = pix_q[B_W-1:0];
    assign FRAME_NEW     = fn_q;
    assign FRAME_CNT     = cnt_q;
endmodule

// File: tb/tb_hdmi_timing_gen_mw.sv
// Randomised bench for hdmi_timing_gen_mw on a tiny 16x8 raster, checked
// every cycle against a frame-position reference model.

module tb_hdmi_timing_gen_mw;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam bit HSP = 1'b0, VSP = 1'b1;
    localparam int L = 2, NW = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                         16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

    typedef struct packed {
        logic [1:0]           mode;
        logic [15:0]          bg;
        logic [NW-1:0]        en;
        logic [NW-1:0][11:0]  x, y, w, h;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    cfg_t              cur;
    logic [16*NW-1:0]  wdata;
    logic [NW-1:0]     win_req;
    logic              hsync, vsync, de, frame_new;
    logic [4:0]        r, b;
    logic [5:0]        g;
    logic [15:0]       frame_cnt;

    hdmi_timing_gen_mw #(
        .HA(HA), .HF(HF), .HS(HS), .HB(HB), .VA(VA), .VF(VF), .VS(VS), .VB(VB),
        .HS_POL(HSP), .VS_POL(VSP), .R_W(5), .G_W(6), .B_W(5),
        .NUM_WIN(NW), .DATA_LATENCY(L)
    ) dut (
        .ADV7513_PCLK (clk),
        .RESETN       (rstn),
        .TEST_MODE    (cur.mode),
        .BG_COLOR     (cur.bg),
        .WIN_EN       (cur.en),
        .WIN_X        (cur.x),
        .WIN_Y        (cur.y),
        .WIN_W        (cur.w),
        .WIN_H        (cur.h),
        .WIN_DATA     (wdata),
        .WIN_REQ      (win_req),
        .ADV7513_HSYNC(hsync),
        .ADV7513_VSYNC(vsync),
        .ADV7513_DE   (de),
        .ADV7513_R    (r),
        .ADV7513_G    (g),
        .ADV7513_B    (b),
        .FRAME_NEW    (frame_new),
        .FRAME_CNT    (frame_cnt)
    );

    int   checks = 0, errors = 0;
    int   cyc, last_c, first_de;
    int   reqcnt [NW];
    cfg_t cfgs [int];
    logic [NW-1:0] hist [8];

    // cycles since reset release; counter position c is live during cycle c
    always @(posedge clk or negedge rstn)
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] src_data(input int i, input int c);
        logic [31:0] t;
        t = 32'(c) * 32'h9E3779B1 + 32'(i) * 32'h85EBCA6B;
        return t[31:16] ^ t[15:0];
    endfunction

    function automatic bit win_in(input cfg_t k, input int i, input int hh, input int vv);
        int x0, y0;
        x0 = int'(k.x[i]);
        y0 = int'(k.y[i]);
        return k.mode == 2'd0 && k.en[i] && hh < HA && vv < VA &&
               hh >= x0 && hh < x0 + int'(k.w[i]) && vv >= y0 && vv < y0 + int'(k.h[i]);
    endfunction

    function automatic logic [NW-1:0] exp_req(input int c);
        logic [NW-1:0] e;
        int pos, q;
        cfg_t k;
        e = '0;
        if (c >= 1) begin
            pos = c - 1;
            q   = pos % FT;
            k   = cfgs[pos / FT];
            for (int i = 0; i < NW; i++) e[i] = win_in(k, i, q % HT, q / HT);
        end
        return e;
    endfunction

    function automatic logic [35:0] exp_pins(input int e);
        int p, f, q, hh, vv;
        cfg_t k;
        logic act, hs, vs, fn;
        logic [15:0] pix, cnt;
        p = e - (L + 2);
        if (p < 0) return {~HSP, ~VSP, 1'b0, 16'h0, 1'b0, 16'h0};
        f = p / FT; q = p % FT; hh = q % HT; vv = q / HT;
        k   = cfgs[f];
        act = hh < HA && vv < VA;
        hs  = (hh >= HA + HF && hh < HA + HF + HS) ? HSP : ~HSP;
        vs  = (vv >= VA + VF && vv < VA + VF + VS) ? VSP : ~VSP;
        fn  = (q == VA * HT);
        cnt = 16'(f + ((q >= VA * HT) ? 1 : 0));
        pix = 16'h0;
        if (act) begin
            case (k.mode)
                2'd1: pix = BARS[(hh / (HA / 8) > 7) ? 7 : hh / (HA / 8)];
                2'd2: pix = (((hh / 32) % 2) != ((vv / 32) % 2)) ? 16'h0000 : 16'hFFFF;
                2'd3: pix = k.bg;
                default: begin
                    pix = k.bg;
                    for (int i = NW - 1; i >= 0; i--)
                        if (win_in(k, i, hh, vv)) pix = src_data(i, p + 1);
                end
            endcase
        end
        return {hs, vs, act, pix, fn, cnt};
    endfunction

    task automatic rand_win(input int i);
        cur.x[i]  = 12'($urandom_range(HA + 2));
        cur.y[i]  = 12'($urandom_range(VA + 1));
        cur.w[i]  = 12'($urandom_range(HA));
        cur.h[i]  = 12'($urandom_range(VA));
        cur.en[i] = 1'($urandom);
    endtask

    task automatic mutate();
        case ($urandom_range(4))
            0:       rand_win($urandom_range(NW - 1));
            1:       cur.en = NW'($urandom);
            2:       cur.bg = 16'($urandom);
            3:       cur.mode = ($urandom_range(3) == 0) ? 2'($urandom) : 2'd0;
            default: begin rand_win(0); rand_win(NW - 1); end
        endcase
    endtask

    // One pixel cycle: act as the sources, check pins/requests, maybe perturb
    task automatic tick(input bit perturb);
        int c;
        @(negedge clk);
        c = cyc;
        last_c = c;
        hist[c % 8] = win_req;
        for (int i = 0; i < NW; i++) begin
            if (c >= L && hist[(c - L) % 8][i]) wdata[16*i +: 16] = src_data(i, c - L);
            else                                wdata[16*i +: 16] = 16'($urandom);
            if (win_req[i]) reqcnt[i]++;
        end
        chk("win_req", 64'(win_req), 64'(exp_req(c)));
        chk("pins", 64'({hsync, vsync, de, r, g, b, frame_new, frame_cnt}), 64'(exp_pins(c)));
        if (de && first_de < 0) first_de = c;
        if (perturb && $urandom_range(60) == 0) mutate();
        if (c % FT == FT - 1) cfgs[c / FT + 1] = cur;
    endtask

    task automatic to_frame_edge(input bit perturb);
        do tick(perturb); while (last_c % FT != 0);
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NW; i++) reqcnt[i] = 0;
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_pins"}, 64'({hsync, vsync, de, r, g, b, frame_new, frame_cnt}),
            64'({~HSP, ~VSP, 1'b0, 16'h0, 1'b0, 16'h0}));
        chk({tag, "_req"}, 64'(win_req), 64'(0));
    endtask

    task automatic release_reset();
        cfgs.delete();
        cfgs[0] = '0;
        first_de = -1;
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    initial begin
        rstn  = 1'b0;
        cur   = '0;
        wdata = '0;
        clr_counts();
        repeat (3) @(posedge clk);
        #1 check_reset_pins("reset");
        cur.bg   = 16'h1234;
        cur.en   = 3'b001;
        cur.x[0] = 12'd4; cur.y[0] = 12'd2; cur.w[0] = 12'd3; cur.h[0] = 12'd2;
        release_reset();

        // frame 0 runs on reset shadows; frames 1 and 2 carry window 0
        repeat (3 * FT + L + 3) tick(1'b0);
        chk("de_first", 64'(first_de), 64'(L + 2));
        chk("fcnt3", 64'(frame_cnt), 64'd3);
        chk("req0_cnt", 64'(reqcnt[0]), 64'd12);

        // identical overlapping windows; drop window 0 mid-frame
        cur.en   = 3'b011;
        cur.x[1] = cur.x[0]; cur.y[1] = cur.y[0]; cur.w[1] = cur.w[0]; cur.h[1] = cur.h[0];
        to_frame_edge(1'b0);
        clr_counts();
        repeat (FT / 2) tick(1'b0);
        cur.en[0] = 1'b0;
        repeat (FT / 2) tick(1'b0);
        chk("ovl_req0", 64'(reqcnt[0]), 64'd6);
        chk("ovl_req1", 64'(reqcnt[1]), 64'd6);
        repeat (FT) tick(1'b0);

        cur.mode = 2'd1;
        to_frame_edge(1'b0);
        repeat (FT + L + 2) tick(1'b0);

        // clipped edge window, zero-width window, window beyond HA
        cur.mode = 2'd0;
        cur.en   = 3'b111;
        cur.x[0] = 12'd15; cur.y[0] = 12'd0; cur.w[0] = 12'd4; cur.h[0] = 12'(VA);
        cur.x[1] = 12'(HA); cur.y[1] = 12'd0; cur.w[1] = 12'd2; cur.h[1] = 12'd3;
        cur.x[2] = 12'd3;  cur.y[2] = 12'd1; cur.w[2] = 12'd0; cur.h[2] = 12'd3;
        to_frame_edge(1'b0);
        clr_counts();
        repeat (FT) tick(1'b0);
        chk("clip_req0", 64'(reqcnt[0]), 64'(VA));
        chk("offscr_req1", 64'(reqcnt[1]), 64'd0);
        chk("w0_req2", 64'(reqcnt[2]), 64'd0);

        cur.mode = 2'd2;
        to_frame_edge(1'b0);
        cur.mode = 2'd3;
        cur.bg   = 16'hBEEF;
        to_frame_edge(1'b0);
        to_frame_edge(1'b0);

        cur.mode = 2'd0;
        repeat (8 * FT) tick(1'b1);

        // asynchronous reset mid-line, then restart
        do tick(1'b1); while (last_c % HT != 7);
        #3 rstn = 1'b0;
        #1 check_reset_pins("midreset");
        repeat (2) @(posedge clk);
        release_reset();
        repeat (2 * FT + L + 3) tick(1'b1);
        chk("de_first_rst", 64'(first_de), 64'(L + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
